// File: rtl/lenet_argmax.sv
// lenet_argmax: picks the highest signed class score of a LeNet output frame.
// A frame is captured on the accept handshake, then scanned one class per
// cycle; ties resolve to the lowest index. The result is held until consumed.
// Optional feature: define LENET_ARGMAX_BIAS_EN to add a per-class bias
// (class_bias) to each score at capture time, saturated to BITWIDTH bits.
module lenet_argmax #(
    parameter int BITWIDTH  = 16,
    parameter int NUM_CLASS = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_CLASS*BITWIDTH-1:0]   featuremap3,
`ifdef LENET_ARGMAX_BIAS_EN
    input  logic [NUM_CLASS*BITWIDTH-1:0]   class_bias,
`endif
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [3:0]                      class_idx,
    output logic signed [BITWIDTH-1:0]      max_score,
    output logic                            busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                      state, state_nxt;
    logic [3:0]                  cnt;
    logic [3:0]                  best_idx;
    logic signed [BITWIDTH-1:0]  best_score;
    logic signed [BITWIDTH-1:0]  frame [NUM_CLASS];
    logic signed [BITWIDTH-1:0]  cap   [NUM_CLASS];
    logic signed [BITWIDTH-1:0]  cur;
    logic                        accept;
    logic                        last;
    logic                        gt;

`ifdef LENET_ARGMAX_BIAS_EN
    // Add at BITWIDTH+1 bits, clamp on overflow to the signed range.
    function automatic logic signed [BITWIDTH-1:0] sat_add(
        input logic signed [BITWIDTH-1:0] a,
        input logic signed [BITWIDTH-1:0] b
    );
        logic signed [BITWIDTH:0] s;
        s = {a[BITWIDTH-1], a} + {b[BITWIDTH-1], b};
        if (s[BITWIDTH] != s[BITWIDTH-1])
            sat_add = s[BITWIDTH] ? {1'b1, {(BITWIDTH-1){1'b0}}}
                                  : {1'b0, {(BITWIDTH-1){1'b1}}};
        else
            sat_add = s[BITWIDTH-1:0];
    endfunction
`endif

    // Unpack the input frame into per-class values to be captured.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CLASS; k++) begin
`ifdef LENET_ARGMAX_BIAS_EN
            cap[k] = sat_add(featuremap3[k*BITWIDTH +: BITWIDTH],
                             class_bias[k*BITWIDTH +: BITWIDTH]);
`else
            cap[k] = featuremap3[k*BITWIDTH +: BITWIDTH];
`endif
        end
    end

    // Scan datapath: current candidate and its strictly-greater test.
    always_comb begin
        cur    = frame[cnt];
        gt     = cur > best_score;
        last   = (cnt == 4'(NUM_CLASS - 1));
        accept = in_valid && in_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = SCAN;
            SCAN:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Frame capture, running maximum and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            best_idx   <= '0;
            best_score <= '0;
            class_idx  <= '0;
            max_score  <= '0;
            for (int unsigned k = 0; k < NUM_CLASS; k++) frame[k] <= '0;
        end else if (accept) begin
            for (int unsigned k = 0; k < NUM_CLASS; k++) frame[k] <= cap[k];
            best_score <= cap[0];
            best_idx   <= '0;
            cnt        <= 4'd1;
        end else if (state == SCAN) begin
            cnt <= cnt + 4'd1;
            if (gt) begin
                best_score <= cur;
                best_idx   <= cnt;
            end
            // Final compare is folded into the result load so DONE sees it.
            if (last) begin
                class_idx <= gt ? cnt : best_idx;
                max_score <= gt ? cur : best_score;
            end
        end
    end

endmodule

// File: tb/tb_lenet_argmax.sv
// Self-checking bench for lenet_argmax: directed corner frames plus random
// frames compared against a plain argmax reference model.
module tb_lenet_argmax;

    localparam int BW = 16;
    localparam int NC = 10;
    localparam int SMAX = (1 << (BW - 1)) - 1;
    localparam int SMIN = -(1 << (BW - 1));

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [NC*BW-1:0]       featuremap3 = '0;
`ifdef LENET_ARGMAX_BIAS_EN
    logic [NC*BW-1:0]       class_bias = '0;
`endif
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [3:0]             class_idx;
    logic signed [BW-1:0]   max_score;
    logic                   busy;

    int errors = 0;
    int checks = 0;

    lenet_argmax #(.BITWIDTH(BW), .NUM_CLASS(NC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .featuremap3 (featuremap3),
`ifdef LENET_ARGMAX_BIAS_EN
        .class_bias  (class_bias),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .class_idx   (class_idx),
        .max_score   (max_score),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    // Reference: argmax over effective scores, first occurrence wins.
    function automatic void ref_model(input int s[NC], input int b[NC],
                                      output int idx, output int mx);
        int eff;
        idx = 0;
        mx  = sat(s[0] + b[0]);
        for (int k = 1; k < NC; k++) begin
            eff = sat(s[k] + b[k]);
            if (eff > mx) begin
                mx  = eff;
                idx = k;
            end
        end
    endfunction

    task automatic load(input int s[NC], input int b[NC]);
        for (int k = 0; k < NC; k++) begin
            featuremap3[k*BW +: BW] = BW'(s[k]);
`ifdef LENET_ARGMAX_BIAS_EN
            class_bias[k*BW +: BW] = BW'(b[k]);
`endif
        end
    endtask

    task automatic scramble();
        for (int k = 0; k < NC; k++) begin
            featuremap3[k*BW +: BW] = BW'($urandom);
`ifdef LENET_ARGMAX_BIAS_EN
            class_bias[k*BW +: BW] = BW'($urandom);
`endif
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", int'(in_ready), 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, n, NC - 1);
    endtask

    // One frame: accept, scramble inputs, check latency, hold, handshake.
    task automatic run_frame(input int s[NC], input int b[NC],
                             input int hold, input bit pulse_in);
        int idx, mx;
        ref_model(s, b, idx, mx);
        load(s, b);
        out_ready = (hold == 0);
        wait_ready();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        check("in_ready_scan", int'(in_ready), 0);
        scramble();
        wait_valid("latency");
        check("class_idx", int'(class_idx), idx);
        check("max_score", int'(max_score), mx);
        for (int i = 0; i < hold; i++) begin
            in_valid = pulse_in;
            tick();
            check("hold_valid", int'(out_valid), 1);
            check("hold_idx", int'(class_idx), idx);
            check("hold_score", int'(max_score), mx);
            check("hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_busy", int'(busy), 0);
        check("retain_idx", int'(class_idx), idx);
        check("retain_score", int'(max_score), mx);
    endtask

    initial begin
        int s[NC];
        int s2[NC];
        int zb[NC];
        int b[NC];
        int idx, mx, seen, mode;

        for (int k = 0; k < NC; k++) zb[k] = 0;

        // Reset state
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_class_idx", int'(class_idx), 0);
        check("rst_max_score", int'(max_score), 0);
        check("rst_busy", int'(busy), 0);
        #4 rst_n = 1'b1;
        tick();
        check("in_ready_after_rst", int'(in_ready), 1);

        // Tie resolved to the lower index
        s = '{3, -1, 7, 2, 7, 0, 5, -8, 1, 6};
        run_frame(s, zb, 0, 1'b0);

        // Signed compare at the extremes
        for (int k = 0; k < NC; k++) s[k] = SMIN;
        s[NC-1] = SMIN + 1;
        run_frame(s, zb, 0, 1'b0);

        // Held result while in_valid pulses during backpressure
        s = '{-5, 12, 40, -100, 39, 40, 0, 1, 2, 3};
        run_frame(s, zb, 20, 1'b1);

        // Reset in the 4th SCAN cycle aborts the frame
        for (int k = 0; k < NC; k++) s[k] = k;
        run_frame(s, zb, 0, 1'b0);
        s = '{1, 2, 3, 4, 5, 60, 7, 8, 9, 10};
        load(s, zb);
        wait_ready();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_class_idx", int'(class_idx), 0);
        check("abort_max_score", int'(max_score), 0);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_busy", int'(busy), 0);
        #2 rst_n = 1'b1;
        tick();
        check("abort_in_ready_release", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);

        // Back-to-back frames with in_valid held high
        s  = '{0, 0, 0, 9, 0, 0, 0, 0, 0, 0};
        s2 = '{-3, -2, -1, -7, -1, -9, -4, -5, -6, -8};
        load(s, zb);
        wait_ready();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        load(s2, zb);
        wait_valid("b2b_latency_a");
        ref_model(s, zb, idx, mx);
        check("b2b_idx_a", int'(class_idx), idx);
        check("b2b_score_a", int'(max_score), mx);
        tick();
        check("b2b_handshake_valid", int'(out_valid), 0);
        check("b2b_handshake_in_ready", int'(in_ready), 1);
        tick();
        check("b2b_reaccept_busy", int'(busy), 1);
        in_valid = 1'b0;
        wait_valid("b2b_latency_b");
        ref_model(s2, zb, idx, mx);
        check("b2b_idx_b", int'(class_idx), idx);
        check("b2b_score_b", int'(max_score), mx);
        tick();
        out_ready = 1'b0;
        check("b2b_done_in_ready", int'(in_ready), 1);

`ifdef LENET_ARGMAX_BIAS_EN
        // Saturating bias
        for (int k = 0; k < NC; k++) begin
            s[k] = 0;
            b[k] = 0;
        end
        s[0] = 32000;
        b[0] = 1000;
        run_frame(s, b, 0, 1'b0);
        check("bias_sat_score", int'(max_score), SMAX);
`endif

        // Random frames: full range, tie-heavy and extreme-value mixes
        for (int f = 0; f < 30; f++) begin
            mode = $urandom_range(0, 2);
            for (int k = 0; k < NC; k++) begin
                case (mode)
                    0:       s[k] = $urandom_range(0, 65535) - 32768;
                    1:       s[k] = $urandom_range(0, 4) - 2;
                    default: s[k] = ($urandom_range(0, 1) == 1) ? SMAX - $urandom_range(0, 1)
                                                                : SMIN + $urandom_range(0, 1);
                endcase
                b[k] = 0;
`ifdef LENET_ARGMAX_BIAS_EN
                b[k] = $urandom_range(0, 65535) - 32768;
`endif
            end
            run_frame(s, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lenet_argmax.md
LENET_ARGMAX -- requirements
Module: lenet_argmax

Interface
REQ-001 Parameter BITWIDTH, default 16, width of each signed score.
REQ-002 Parameter NUM_CLASS, default 10, number of class scores per frame; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  a score frame is presented on featuremap3.
REQ-006 in_ready  output  1  block can accept a frame.
REQ-007 featuremap3  input  NUM_CLASS x BITWIDTH signed  class scores from the final conv stage, index 0..NUM_CLASS-1.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 class_idx  output  4  index of the winning class.
REQ-011 max_score  output  BITWIDTH signed  winning score, after bias when biasing is enabled.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, SCAN and DONE.
REQ-014 In IDLE: in_ready=1, out_valid=0. A frame is accepted on any edge where in_valid and in_ready are both high.
REQ-015 On acceptance, the block SHALL:
- capture all NUM_CLASS scores into an internal frame register;
- load best_score with score[0] and best_idx with 0;
- set the scan counter to 1;
- enter SCAN.
REQ-016 featuremap3 SHALL be sampled only on the acceptance edge; later input changes SHALL have no effect on the result.
REQ-017 In SCAN: in_ready=0. Each cycle the block SHALL compare captured[cnt] with best_score and then increment cnt.
REQ-018 The comparison SHALL be a signed, strictly-greater test, so ties keep the lowest index.
REQ-019 After processing cnt=NUM_CLASS-1, the block SHALL enter DONE.
- Latency: out_valid rises NUM_CLASS-1 edges after the acceptance edge (9 edges for the default).
REQ-020 In DONE: out_valid=1. class_idx and max_score SHALL be held stable until out_ready is sampled high.
REQ-021 On the edge where out_valid and out_ready are both high, the block SHALL return to IDLE.
- in_ready rises on the following cycle; there is no same-cycle re-accept.
REQ-022 in_valid while busy SHALL be ignored. No frame is queued or dropped silently, because in_ready=0 throughout.
REQ-023 In IDLE, class_idx and max_score SHALL retain the last result.

Reset
REQ-024 When rst_n is low, the block SHALL asynchronously force:
- state=IDLE;
- out_valid=0, class_idx=0, max_score=0;
- cnt=0, best registers=0, frame register=0.
REQ-025 Reset asserted mid-SCAN or in DONE SHALL abort the frame. No out_valid pulse SHALL follow reset release.
REQ-026 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-027 The macro LENET_ARGMAX_BIAS_EN SHALL control a per-class bias input.
REQ-028 With LENET_ARGMAX_BIAS_EN defined:
- the block SHALL add a port class_bias (input, NUM_CLASS x BITWIDTH signed);
- on the acceptance edge, each captured score SHALL be score[k]+class_bias[k];
- each sum SHALL be computed at BITWIDTH+1 bits and saturated to the signed BITWIDTH range;
- latency SHALL be unchanged.
REQ-029 With LENET_ARGMAX_BIAS_EN undefined, the class_bias port SHALL be absent and scores SHALL be captured unmodified.

Verification
REQ-030 Scores {3,-1,7,2,7,0,5,-8,1,6} accepted with out_ready=1 -> out_valid high 9 edges later with class_idx=2 and max_score=7 (tie resolved to the lower index).
REQ-031 All scores -32768 except score[9]=-32767 -> class_idx=9, max_score=-32767 (signed compare at the extremes).
REQ-032 out_ready held low for 20 cycles after out_valid, with in_valid pulsed during that window -> result stable, in_ready=0 throughout, no second frame accepted.
REQ-033 rst_n pulsed low at the 4th SCAN cycle -> immediate IDLE with outputs 0, in_ready=1 after release, no out_valid.
REQ-034 Back-to-back frames with in_valid held high -> second acceptance exactly one cycle after the result handshake, and both results correct.
REQ-035 With LENET_ARGMAX_BIAS_EN defined: score[0]=32000 and bias[0]=1000, all other scores 0 and biases 0 -> max_score=32767 (saturated), class_idx=0.
